// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: Booth multiply, unsigned shift-add, or restoring divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  muldiv_op_t       op,
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] a_shl;

    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        sum       = a;
        a_shl     = {a[WIDTH-1:0], q[WIDTH-1]};
        a_next    = a;
        q_next    = q;
        q_m1_next = q_m1;
        case (op)
            OP_MULT: begin
                case ({q[0], q_m1})
                    2'b01:   sum = a + m;
                    2'b10:   sum = a - m;
                    default: sum = a;
                endcase
                a_next    = {sum[WIDTH], sum[WIDTH:1]};
                q_next    = {sum[0], q[WIDTH-1:1]};
                q_m1_next = q[0];
            end
            OP_MULTU: begin
                sum       = q[0] ? a + m : a;
                a_next    = {1'b0, sum[WIDTH:1]};
                q_next    = {sum[0], q[WIDTH-1:1]};
                q_m1_next = q[0];
            end
            default: begin
                // Shift {A,Q} left, then keep the trial subtraction only if it did not go negative.
                if (a_shl >= m) begin
                    a_next = a_shl - m;
                    q_next = {q[WIDTH-2:0], 1'b1};
                end else begin
                    a_next = a_shl;
                    q_next = {q[WIDTH-2:0], 1'b0};
                end
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU unit: fixed WIDTH+1 cycle latency, results in HI/LO, stall while busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    output logic [WIDTH-1:0] hi_output,
    output logic [WIDTH-1:0] lo_output,
    output logic             stall,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    muldiv_state_t    state, next_state;
    muldiv_op_t       op_in, op_reg;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   acc, acc_next, m_reg;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             q_m1, q_m1_next;
    logic             neg_q, neg_r, div_zero;
    logic             accept, is_div_in, sign_1, sign_2;
    logic [WIDTH-1:0] mag_1, mag_2, rem, quo, hi_fix, lo_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op        (op_reg),
        .a         (acc),
        .q         (q_reg),
        .q_m1      (q_m1),
        .m         (m_reg),
        .a_next    (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept     = 1'b1;
                next_state = RUN;
            end
            RUN:     if (count == CNT_W'(1)) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign stall = (state != IDLE);

    always_comb begin
        op_in     = muldiv_op_t'(op);
        sign_1    = input_1[WIDTH-1];
        sign_2    = input_2[WIDTH-1];
        is_div_in = (op_in == OP_DIV) || (op_in == OP_DIVU);
        mag_1     = (op_in == OP_DIV && sign_1) ? -input_1 : input_1;
        mag_2     = (op_in == OP_DIV && sign_2) ? -input_2 : input_2;
    end

    // Divide-by-zero leaves the dividend magnitude in A, so the sign-fixed remainder is the dividend.
    // The DIV overflow case falls out naturally: -MIN wraps back to MIN and the remainder is 0.
    always_comb begin
        rem = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        quo = neg_q ? -q_reg : q_reg;
        if (op_reg == OP_MULT || op_reg == OP_MULTU) begin
            hi_fix = acc[WIDTH-1:0];
            lo_fix = q_reg;
        end else begin
            hi_fix = rem;
            lo_fix = div_zero ? '1 : quo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            acc       <= '0;
            q_reg     <= '0;
            q_m1      <= 1'b0;
            m_reg     <= '0;
            op_reg    <= OP_MULT;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            hi_output <= '0;
            lo_output <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == FINISH);
            if (accept) begin
                op_reg   <= op_in;
                count    <= CNT_W'(WIDTH);
                acc      <= '0;
                q_m1     <= 1'b0;
                q_reg    <= is_div_in ? mag_1 : input_1;
                m_reg    <= {(op_in == OP_MULT) && sign_2, is_div_in ? mag_2 : input_2};
                neg_q    <= (op_in == OP_DIV) && (sign_1 ^ sign_2);
                neg_r    <= (op_in == OP_DIV) && sign_1;
                div_zero <= is_div_in && (input_2 == '0);
            end else if (state == RUN) begin
                acc   <= acc_next;
                q_reg <= q_next;
                q_m1  <= q_m1_next;
                count <= count - CNT_W'(1);
            end else if (state == FINISH) begin
                hi_output <= hi_fix;
                lo_output <= lo_fix;
            end
        end
    end

endmodule
